// File: rtl/alu_multdiv.sv
// Execute-stage ALU: single-cycle add/sub/logic/shift plus iterative signed multiply
// (shift-add) and divide (restoring), with registered results behind a valid/ready handshake.
module alu_multdiv #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_operandA,
    input  logic [WIDTH-1:0]         data_operandB,
    input  logic [4:0]               ctrl_ALUopcode,
    input  logic [$clog2(WIDTH)-1:0] ctrl_shiftamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_result,
    output logic                     isNotEqual,
    output logic                     isLessThan,
    output logic                     overflow,
    output logic                     data_exception
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0]   res_q, res_d;
    logic               valid_q, valid_d, ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mag_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               neg_q, is_div_q, div_zero_q, div_exc_q, ne_p_q, lt_p_q;

    logic accept, is_mul, is_div, single;
    logic [WIDTH-1:0] sum, diff, alu_res, a_mag, b_mag;
    logic ovf_add, ovf_sub, cmp_lt, cmp_ne, alu_ovf, alu_exc;

    assign accept  = in_valid && in_ready;
    assign is_mul  = MULDIV_EN && (ctrl_ALUopcode == 5'b00110);
    assign is_div  = MULDIV_EN && (ctrl_ALUopcode == 5'b00111);
    assign single  = !is_mul && !is_div;
    assign sum     = data_operandA + data_operandB;
    assign diff    = data_operandA - data_operandB;
    assign ovf_add = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) && (sum[WIDTH-1] != data_operandA[WIDTH-1]);
    assign ovf_sub = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) && (diff[WIDTH-1] != data_operandA[WIDTH-1]);
    // Sign of the difference corrected by its overflow gives a true signed compare.
    assign cmp_lt  = diff[WIDTH-1] ^ ovf_sub;
    assign cmp_ne  = data_operandA != data_operandB;
    assign a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_exc = 1'b0;
        case (ctrl_ALUopcode)
            5'b00000: begin alu_res = sum;  alu_ovf = ovf_add; end
            5'b00001: begin alu_res = diff; alu_ovf = ovf_sub; end
            5'b00010: alu_res = data_operandA & data_operandB;
            5'b00011: alu_res = data_operandA | data_operandB;
            5'b00100: alu_res = data_operandA << ctrl_shiftamt;
            5'b00101: alu_res = $signed(data_operandA) >>> ctrl_shiftamt;
            default:  alu_exc = 1'b1;
        endcase
    end

    // Multiply keeps {accumulator, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_signed;
    logic [WIDTH-1:0]   quot_signed;
    logic               mul_exc;

    assign mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next    = {mul_sum, prod_q[WIDTH-1:1]};
    assign div_shift   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_trial   = div_shift - {1'b0, mag_q};
    assign div_next    = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                          : {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    assign prod_signed = neg_q ? -prod_q : prod_q;
    assign mul_exc     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    assign quot_signed = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (accept && is_mul) state_d = S_MUL;
                          else if (accept && is_div) state_d = S_DIV;
            S_MUL, S_DIV: if (cnt_q == SHAMT_W'(WIDTH-1)) state_d = S_DONE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE) && (!valid_q || out_ready);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_q <= '0; mag_q <= '0; cnt_q <= '0; neg_q <= 1'b0; is_div_q <= 1'b0;
            div_zero_q <= 1'b0; div_exc_q <= 1'b0; ne_p_q <= 1'b0; lt_p_q <= 1'b0;
        end else if (accept && !single) begin
            prod_q     <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            mag_q      <= is_div ? b_mag : a_mag;
            cnt_q      <= '0;
            neg_q      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            is_div_q   <= is_div;
            div_zero_q <= (data_operandB == '0);
            div_exc_q  <= (data_operandB == '0) ||
                          ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB));
            ne_p_q     <= cmp_ne;
            lt_p_q     <= cmp_lt;
        end else if (state_q == S_MUL || state_q == S_DIV) begin
            prod_q <= (state_q == S_MUL) ? mul_next : div_next;
            cnt_q  <= cnt_q + SHAMT_W'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        ne_d    = ne_q;
        lt_d    = lt_q;
        ovf_d   = ovf_q;
        exc_d   = exc_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (accept && single) begin
            valid_d = 1'b1; res_d = alu_res; ne_d = cmp_ne; lt_d = cmp_lt;
            ovf_d = alu_ovf; exc_d = alu_exc;
        end else if (state_q == S_DONE) begin
            valid_d = 1'b1; ne_d = ne_p_q; lt_d = lt_p_q; ovf_d = 1'b0;
            if (is_div_q) begin
                res_d = div_zero_q ? '0 : quot_signed;
                exc_d = div_exc_q;
            end else begin
                res_d = prod_signed[WIDTH-1:0];
                exc_d = mul_exc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0; res_q <= '0; ne_q <= 1'b0; lt_q <= 1'b0; ovf_q <= 1'b0; exc_q <= 1'b0;
        end else begin
            valid_q <= valid_d; res_q <= res_d; ne_q <= ne_d; lt_q <= lt_d; ovf_q <= ovf_d; exc_q <= exc_d;
        end
    end

    assign out_valid      = valid_q;
    assign data_result    = res_q;
    assign isNotEqual     = ne_q;
    assign isLessThan     = lt_q;
    assign overflow       = ovf_q;
    assign data_exception = exc_q;
endmodule
